ps2_cursor_ctrl: RTL and testbench

//  Parametrised PS/2 keyboard receiver and cursor/colour controller, fully synchronous to the system Clock.

---
 rtl/ps2_cursor_ctrl_if.sv | 40 ++++
 rtl/ps2_cursor_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_ps2_cursor_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_cursor_ctrl_if.sv
// ps2_cursor_ctrl_if
//   Bundle of the PS/2 pin inputs and the cursor/colour/key-event outputs of
//   ps2_cursor_ctrl. Clock and reset are kept as plain module ports.
//   master : the controller (samples the pins, drives cursor and event outputs)
//   slave  : the environment (drives the pins, consumes cursor and events)
//   Signals:
//     PS2_CLK, PS2_DATA        raw asynchronous PS/2 pins
//     XCounter, YCounter       cursor position (COORD_W bits)
//     ColorReg                 current colour (COLOR_W bits)
//     ScanCode                 last non-prefix code byte
//     ScanValid                1-cycle key event pulse
//     KeyBreak, KeyExtended    event qualifiers, valid with ScanValid
//     FrameError               1-cycle parity/stop/timeout error pulse
interface ps2_cursor_ctrl_if #(
    parameter int COORD_W = 8,
    parameter int COLOR_W = 3
);
    logic               PS2_CLK;
    logic               PS2_DATA;
    logic [COORD_W-1:0] XCounter;
    logic [COORD_W-1:0] YCounter;
    logic [COLOR_W-1:0] ColorReg;
    logic [7:0]         ScanCode;
    logic               ScanValid;
    logic               KeyBreak;
    logic               KeyExtended;
    logic               FrameError;

    modport master (
        input  PS2_CLK, PS2_DATA,
        output XCounter, YCounter, ColorReg, ScanCode,
               ScanValid, KeyBreak, KeyExtended, FrameError
    );

    modport slave (
        output PS2_CLK, PS2_DATA,
        input  XCounter, YCounter, ColorReg, ScanCode,
               ScanValid, KeyBreak, KeyExtended, FrameError
    );
endinterface

// File: rtl/ps2_cursor_ctrl.sv
// ps2_cursor_ctrl
//   PS/2 keyboard receiver plus cursor/colour controller, fully synchronous
//   to Clock. Oversamples the PS/2 pins, decodes 11-bit frames (start, 8 data
//   LSB first, odd parity, stop) with parity/stop/timeout checking, tracks the
//   E0/F0 prefixes and applies WASD / arrow / space actions to the cursor and
//   colour registers. Edges clamp (WRAP=0) or wrap modulo MAX+1 (WRAP=1).
//   Ports:
//     Clock    system clock, rising edge
//     Reset_n  asynchronous active-low reset
//     bus      ps2_cursor_ctrl_if.master (pins in, cursor/event outputs out)
module ps2_cursor_ctrl #(
    parameter int COORD_W     = 8,
    parameter int STEP        = 32,
    parameter int X_MAX       = 255,
    parameter int Y_MAX       = 255,
    parameter int COLOR_W     = 3,
    parameter int WRAP        = 0,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    ps2_cursor_ctrl_if.master    bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam int VW   = COORD_W + 1;
    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [VW-1:0]   STEP_V = VW'(STEP);
    localparam logic [VW-1:0]   XMAX_V = VW'(X_MAX);
    localparam logic [VW-1:0]   YMAX_V = VW'(Y_MAX);
    localparam logic [TO_W-1:0] TO_END = TO_W'(TIMEOUT_CYC - 1);

    // Coordinate arithmetic is one bit wider than the counters so the
    // overflow/underflow tests below are exact.
    function automatic logic [VW-1:0] step_inc(input logic [VW-1:0] v,
                                               input logic [VW-1:0] vmax);
        logic [VW-1:0] s;
        s = v + STEP_V;
        if (s > vmax) begin
            step_inc = (WRAP != 0) ? (s - vmax - VW'(1)) : vmax;
        end else begin
            step_inc = s;
        end
    endfunction

    function automatic logic [VW-1:0] step_dec(input logic [VW-1:0] v,
                                               input logic [VW-1:0] vmax);
        if (v < STEP_V) begin
            step_dec = (WRAP != 0) ? (v + vmax + VW'(1) - STEP_V) : '0;
        end else begin
            step_dec = v - STEP_V;
        end
    endfunction

    // Pin synchronisers; clk_prev_q holds the previous synced clock for
    // falling-edge detection.
    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic dat_s1_q, dat_s2_q;

    logic [1:0]         state_q,  state_d;
    logic [2:0]         bitcnt_q, bitcnt_d;
    logic [7:0]         shreg_q,  shreg_d;
    logic               parity_q, parity_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               ext_q,    ext_d;
    logic               brk_q,    brk_d;

    logic [COORD_W-1:0] x_q,      x_d;
    logic [COORD_W-1:0] y_q,      y_d;
    logic [COLOR_W-1:0] color_q,  color_d;
    logic [7:0]         code_q,   code_d;
    logic               sv_q,     sv_d;
    logic               kbrk_q,   kbrk_d;
    logic               kext_q,   kext_d;
    logic               fe_q,     fe_d;

    logic fall;
    logic byte_ok;
    logic frame_err;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_s1_q   <= 1'b0;
            clk_s2_q   <= 1'b0;
            clk_prev_q <= 1'b0;
            dat_s1_q   <= 1'b0;
            dat_s2_q   <= 1'b0;
        end else begin
            clk_s1_q   <= bus.PS2_CLK;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= bus.PS2_DATA;
            dat_s2_q   <= dat_s1_q;
        end
    end

    always_comb begin
        fall      = clk_prev_q & ~clk_s2_q;
        byte_ok   = 1'b0;
        frame_err = 1'b0;

        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        parity_d = parity_q;
        ext_d    = ext_q;
        brk_d    = brk_q;
        x_d      = x_q;
        y_d      = y_q;
        color_d  = color_q;
        code_d   = code_q;
        kbrk_d   = kbrk_q;
        kext_d   = kext_q;
        sv_d     = 1'b0;
        fe_d     = 1'b0;

        // Counter only matters inside a frame, so it rests at zero in IDLE.
        if (fall || state_q == ST_IDLE) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (fall && !dat_s2_q) begin
                    state_d  = ST_DATA;
                    bitcnt_d = '0;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shreg_d  = {dat_s2_q, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    parity_d = dat_s2_q;
                    state_d  = ST_STOP;
                end
            end
            default: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    if (((^shreg_q) ^ parity_q) && dat_s2_q) begin
                        byte_ok = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
            end
        endcase

        if (state_q != ST_IDLE && !fall && to_cnt_q == TO_END) begin
            state_d   = ST_IDLE;
            frame_err = 1'b1;
        end

        if (frame_err) begin
            fe_d  = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
        end

        if (byte_ok) begin
            if (shreg_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shreg_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                sv_d   = 1'b1;
                code_d = shreg_q;
                kbrk_d = brk_q;
                kext_d = ext_q;
                ext_d  = 1'b0;
                brk_d  = 1'b0;
                if (!brk_q) begin
                    case ({ext_q, shreg_q})
                        9'h01D, 9'h175: y_d = COORD_W'(step_dec(VW'(y_q), YMAX_V));
                        9'h01B, 9'h172: y_d = COORD_W'(step_inc(VW'(y_q), YMAX_V));
                        9'h01C, 9'h16B: x_d = COORD_W'(step_dec(VW'(x_q), XMAX_V));
                        9'h023, 9'h174: x_d = COORD_W'(step_inc(VW'(x_q), XMAX_V));
                        9'h029:         color_d = color_q + COLOR_W'(1);
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            parity_q <= 1'b0;
            to_cnt_q <= '0;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            color_q  <= COLOR_W'(1);
            code_q   <= '0;
            sv_q     <= 1'b0;
            kbrk_q   <= 1'b0;
            kext_q   <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            parity_q <= parity_d;
            to_cnt_q <= to_cnt_d;
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            x_q      <= x_d;
            y_q      <= y_d;
            color_q  <= color_d;
            code_q   <= code_d;
            sv_q     <= sv_d;
            kbrk_q   <= kbrk_d;
            kext_q   <= kext_d;
            fe_q     <= fe_d;
        end
    end

    assign bus.XCounter    = x_q;
    assign bus.YCounter    = y_q;
    assign bus.ColorReg    = color_q;
    assign bus.ScanCode    = code_q;
    assign bus.ScanValid   = sv_q;
    assign bus.KeyBreak    = kbrk_q;
    assign bus.KeyExtended = kext_q;
    assign bus.FrameError  = fe_q;

endmodule

// File: tb/tb_ps2_cursor_ctrl.sv
// tb_ps2_cursor_ctrl
//   Drives two controllers (clamping and wrapping) from the same PS/2 pins
//   with directed and random frames, and compares cursor, colour and key
//   events against a behavioural keyboard/cursor model.
module tb_ps2_cursor_ctrl;

    localparam int TO_CYC = 100;
    localparam int HALF   = 10;
    localparam int MAXV   = 255;
    localparam int STP    = 32;

    logic Clock;
    logic Reset_n;
    logic ps2_clk;
    logic ps2_data;

    ps2_cursor_ctrl_if #(.COORD_W(8), .COLOR_W(3)) bus_a ();
    ps2_cursor_ctrl_if #(.COORD_W(8), .COLOR_W(3)) bus_b ();

    assign bus_a.PS2_CLK  = ps2_clk;
    assign bus_a.PS2_DATA = ps2_data;
    assign bus_b.PS2_CLK  = ps2_clk;
    assign bus_b.PS2_DATA = ps2_data;

    ps2_cursor_ctrl #(.WRAP(0), .TIMEOUT_CYC(TO_CYC)) u_clamp (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus_a)
    );

    ps2_cursor_ctrl #(.WRAP(1), .TIMEOUT_CYC(TO_CYC)) u_wrap (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus_b)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Event monitor on the clamping instance.
    int sv_cnt = 0;
    int fe_cnt = 0;
    logic [7:0] cap_code;
    logic cap_brk, cap_ext;

    always @(negedge Clock) begin
        if (bus_a.ScanValid === 1'b1) begin
            sv_cnt++;
            cap_code = bus_a.ScanCode;
            cap_brk  = bus_a.KeyBreak;
            cap_ext  = bus_a.KeyExtended;
        end
        if (bus_a.FrameError === 1'b1) fe_cnt++;
    end

    // Reference model: index 0 clamps, index 1 wraps.
    int  mx[2];
    int  my[2];
    int  mcol;
    bit  mext, mbrk;
    bit  exp_ev;
    int  exp_code;
    bit  exp_brk, exp_ext;

    function automatic int mv(input int v, input int d, input bit wrap);
        int n;
        n = v + d;
        if (n < 0)    return wrap ? n + MAXV + 1 : 0;
        if (n > MAXV) return wrap ? n - MAXV - 1 : MAXV;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mx[i] = 0;
            my[i] = 0;
        end
        mcol = 1;
        mext = 0;
        mbrk = 0;
    endtask

    task automatic model_byte(input int b);
        int dx, dy;
        exp_ev = 0;
        if (b == 'hE0) begin
            mext = 1;
        end else if (b == 'hF0) begin
            mbrk = 1;
        end else begin
            exp_ev   = 1;
            exp_code = b;
            exp_brk  = mbrk;
            exp_ext  = mext;
            dx = 0;
            dy = 0;
            if (!mbrk) begin
                if (!mext) begin
                    if (b == 'h1D) dy = -STP;
                    if (b == 'h1B) dy = STP;
                    if (b == 'h1C) dx = -STP;
                    if (b == 'h23) dx = STP;
                    if (b == 'h29) mcol = (mcol + 1) % 8;
                end else begin
                    if (b == 'h75) dy = -STP;
                    if (b == 'h72) dy = STP;
                    if (b == 'h6B) dx = -STP;
                    if (b == 'h74) dx = STP;
                end
                for (int i = 0; i < 2; i++) begin
                    mx[i] = mv(mx[i], dx, i == 1);
                    my[i] = mv(my[i], dy, i == 1);
                end
            end
            mext = 0;
            mbrk = 0;
        end
    endtask

    task automatic model_error();
        mext = 0;
        mbrk = 0;
    endtask

    // Sends the first nbits bits of a frame: start, data LSB first, parity, stop.
    task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] fr;
        fr[0]   = 1'b0;
        fr[8:1] = b;
        fr[9]   = (~^b) ^ bad_par;
        fr[10]  = ~bad_stop;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            repeat (HALF) @(posedge Clock);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge Clock);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, " x"},     bus_a.XCounter, mx[0]);
        check_eq({tag, " y"},     bus_a.YCounter, my[0]);
        check_eq({tag, " color"}, bus_a.ColorReg, mcol);
        check_eq({tag, " xw"},    bus_b.XCounter, mx[1]);
        check_eq({tag, " yw"},    bus_b.YCounter, my[1]);
    endtask

    task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        int sv0, fe0;
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        send_bits(b, bad_par, bad_stop, 11);
        repeat (4) @(posedge Clock);
        if (bad_par || bad_stop) begin
            model_error();
            exp_ev = 0;
            check_eq("frame_error", fe_cnt - fe0, 1);
        end else begin
            model_byte(int'(b));
            check_eq("frame_error", fe_cnt - fe0, 0);
        end
        check_eq("scan_valid", sv_cnt - sv0, exp_ev ? 1 : 0);
        if (exp_ev) begin
            check_eq("scan_code", cap_code, exp_code);
            check_eq("key_break", cap_brk, exp_brk);
            check_eq("key_ext",   cap_ext, exp_ext);
        end
        check_state("frame");
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        model_reset();
        repeat (5) @(posedge Clock);
    endtask

    initial begin
        logic [7:0] codes [14];
        int sv0, fe0;
        codes = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'hE0, 8'hF0,
                  8'h75, 8'h72, 8'h6B, 8'h74, 8'h12, 8'hE0, 8'hF0};
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        Reset_n  = 1'b0;
        model_reset();
        repeat (3) @(posedge Clock);
        #1;
        check_eq("rst x",     bus_a.XCounter, 0);
        check_eq("rst y",     bus_a.YCounter, 0);
        check_eq("rst color", bus_a.ColorReg, 1);
        check_eq("rst code",  bus_a.ScanCode, 0);
        check_eq("rst sv",    bus_a.ScanValid, 0);
        check_eq("rst fe",    bus_a.FrameError, 0);
        Reset_n = 1'b1;
        repeat (5) @(posedge Clock);

        // Clamp at Y=0, then move right.
        frame(8'h1D, 0, 0);
        frame(8'h23, 0, 0);
        check_eq("x after D", bus_a.XCounter, 32);

        // Extended release: single event, no movement.
        frame(8'hE0, 0, 0);
        frame(8'hF0, 0, 0);
        frame(8'h74, 0, 0);
        check_eq("x after E0F074", bus_a.XCounter, 32);

        // Colour cycles through all values.
        do_reset();
        for (int i = 0; i < 8; i++) frame(8'h29, 0, 0);
        check_eq("color wrapped", bus_a.ColorReg, 1);

        // Left from zero: wrap vs clamp; then walk right into the edge.
        frame(8'h1C, 0, 0);
        check_eq("wrap left", bus_b.XCounter, 224);
        check_eq("clamp left", bus_a.XCounter, 0);
        for (int i = 0; i < 9; i++) frame(8'h23, 0, 0);
        check_eq("clamp right", bus_a.XCounter, 255);

        // Errors and prefix clearing.
        frame(8'h23, 1, 0);
        frame(8'hF0, 0, 0);
        frame(8'h44, 1, 0);
        frame(8'h1B, 0, 0);
        frame(8'hE0, 0, 0);
        frame(8'h44, 0, 1);
        frame(8'h1B, 0, 0);

        // Timeout mid-frame after a break prefix.
        frame(8'hF0, 0, 0);
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        send_bits(8'h1B, 0, 0, 5);
        repeat (TO_CYC + 20) @(posedge Clock);
        model_error();
        check_eq("timeout fe", fe_cnt - fe0, 1);
        check_eq("timeout sv", sv_cnt - sv0, 0);
        frame(8'h1B, 0, 0);

        // Random traffic.
        for (int n = 0; n < 60; n++) begin
            logic [7:0] b;
            int r;
            b = codes[$urandom_range(0, 13)];
            if (b == 8'h12) b = 8'($urandom);
            r = int'($urandom_range(0, 19));
            frame(b, r < 2, r == 2);
        end

        // Reset in the middle of a frame.
        send_bits(8'h1B, 0, 0, 5);
        Reset_n = 1'b0;
        #1;
        model_reset();
        check_eq("midrst x",     bus_a.XCounter, 0);
        check_eq("midrst y",     bus_a.YCounter, 0);
        check_eq("midrst color", bus_a.ColorReg, 1);
        check_eq("midrst code",  bus_a.ScanCode, 0);
        check_eq("midrst sv",    bus_a.ScanValid, 0);
        check_eq("midrst fe",    bus_a.FrameError, 0);
        repeat (3) @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        repeat (5) @(posedge Clock);
        frame(8'h1B, 0, 0);
        check_eq("post rst y", bus_a.YCounter, 32);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
